// File: rtl/fifo_wr_arb_ctrl.sv
// fifo_wr_arb_ctrl
// Write-side controller for a two-requester FIFO built around an external
// dual-port memory. It arbitrates between two writers (round-robin on ties),
// holds the binary read/write pointers, and derives the empty/full/count and
// threshold flags from them. Reads are first-word fall-through: the head word
// sits at mem_raddr whenever the FIFO is not empty.

module fifo_wr_arb_ctrl #(
    parameter int DATASIZE  = 8,
    parameter int ADDRSIZE  = 4,
    parameter int AFULL_TH  = (2 ** ADDRSIZE) - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                req0,
    input  logic                req1,
    input  logic [DATASIZE-1:0] wdata0,
    input  logic [DATASIZE-1:0] wdata1,
    output logic                gnt0,
    output logic                gnt1,
    input  logic                rinc,
    output logic                rempty,
    output logic                wfull,
    output logic [ADDRSIZE:0]   count,
    output logic                almost_full,
    output logic                almost_empty,
    output logic                underflow,
    output logic [DATASIZE-1:0] mem_wdata,
    output logic [ADDRSIZE-1:0] mem_waddr,
    output logic                mem_wclken,
    output logic [ADDRSIZE-1:0] mem_raddr
);

    localparam logic [ADDRSIZE:0] PTR_ONE   = (ADDRSIZE + 1)'(1'b1);
    localparam logic [ADDRSIZE:0] PTR_ZERO  = (ADDRSIZE + 1)'(1'b0);
    localparam logic [ADDRSIZE:0] AFULL_C   = (ADDRSIZE + 1)'(AFULL_TH);
    localparam logic [ADDRSIZE:0] AEMPTY_C  = (ADDRSIZE + 1)'(AEMPTY_TH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDRSIZE:0] r_wptr;
    logic [ADDRSIZE:0] r_rptr;
    // 1'b1 means requester 1 was granted last; requester 0 then wins a tie.
    logic              r_last_gnt1;
    logic              r_underflow;

    logic              w_empty;
    logic              w_full;
    logic [ADDRSIZE:0] w_count;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_wr_en;
    logic              w_rd_en;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[ADDRSIZE] != r_rptr[ADDRSIZE]) &&
                     (r_wptr[ADDRSIZE-1:0] == r_rptr[ADDRSIZE-1:0]);
    assign w_count = r_wptr - r_rptr;

    // Round-robin arbiter: grants are combinational and suppressed while full,
    // so a pop in the same cycle as full cannot open a write slot early.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (w_full) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end else begin
            case ({req1, req0})
                2'b01: w_gnt0 = 1'b1;
                2'b10: w_gnt1 = 1'b1;
                2'b11: begin
                    if (r_last_gnt1) begin
                        w_gnt0 = 1'b1;
                    end else begin
                        w_gnt1 = 1'b1;
                    end
                end
                default: begin
                    w_gnt0 = 1'b0;
                    w_gnt1 = 1'b0;
                end
            endcase
        end
    end

    assign w_wr_en = w_gnt0 | w_gnt1;
    // A pop only counts when something is stored; a pop on empty is an error.
    assign w_rd_en = rinc & ~w_empty;

    // Pointer, arbitration-history and sticky underflow state.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_wptr      <= PTR_ZERO;
            r_rptr      <= PTR_ZERO;
            r_last_gnt1 <= 1'b1;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wptr      <= r_wptr + PTR_ONE;
                r_last_gnt1 <= w_gnt1;
            end
            if (w_rd_en) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            if (rinc && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign gnt0         = w_gnt0;
    assign gnt1         = w_gnt1;
    assign rempty       = w_empty;
    assign wfull        = w_full;
    assign count        = w_count;
    assign almost_full  = (w_count >= AFULL_C);
    assign almost_empty = (w_count <= AEMPTY_C);
    assign underflow    = r_underflow;
    assign mem_wclken   = w_wr_en;
    assign mem_wdata    = w_gnt1 ? wdata1 : wdata0;
    assign mem_waddr    = r_wptr[ADDRSIZE-1:0];
    assign mem_raddr    = r_rptr[ADDRSIZE-1:0];

endmodule

// File: tb/tb_fifo_wr_arb_ctrl.sv
// Testbench for fifo_wr_arb_ctrl (default parameters: 8-bit data, 16 words).
// Directed stimulus pushes expected writes/reads into queues; a monitor on the
// falling clock edge pops and compares whenever the DUT writes or pops. Flags
// are compared against hand-derived counts after each clock edge.

module tb_fifo_wr_arb_ctrl;

    logic       wclk;
    logic       wrst;
    logic       req0, req1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1;
    logic       rinc;
    logic       rempty, wfull;
    logic [4:0] count;
    logic       almost_full, almost_empty, underflow;
    logic [7:0] mem_wdata;
    logic [3:0] mem_waddr;
    logic       mem_wclken;
    logic [3:0] mem_raddr;

    fifo_wr_arb_ctrl dut (
        .wclk        (wclk),
        .wrst        (wrst),
        .req0        (req0),
        .req1        (req1),
        .wdata0      (wdata0),
        .wdata1      (wdata1),
        .gnt0        (gnt0),
        .gnt1        (gnt1),
        .rinc        (rinc),
        .rempty      (rempty),
        .wfull       (wfull),
        .count       (count),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .underflow   (underflow),
        .mem_wdata   (mem_wdata),
        .mem_waddr   (mem_waddr),
        .mem_wclken  (mem_wclken),
        .mem_raddr   (mem_raddr)
    );

    typedef struct {
        logic [7:0] d;
        logic [3:0] a;
    } wr_t;

    wr_t        q_wr[$];
    logic [7:0] q_rd[$];
    logic [7:0] tb_mem [16];

    int n_tests = 0;
    int n_fail  = 0;
    int wcount  = 0;
    bit exp_uf  = 1'b0;

    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    // Memory model attached to the DUT's write port.
    always @(posedge wclk) begin
        if (mem_wclken && !wfull) tb_mem[mem_waddr] <= mem_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: compare every write and every valid pop.
    always @(negedge wclk) begin
        if (!wrst) begin
            if (mem_wclken) begin
                if (q_wr.size() == 0) begin
                    chk("wr_unexpected", 32'd1, 32'd0);
                end else begin
                    wr_t e;
                    e = q_wr.pop_front();
                    chk("wr_data", {24'd0, mem_wdata}, {24'd0, e.d});
                    chk("wr_addr", {28'd0, mem_waddr}, {28'd0, e.a});
                end
            end
            if (rinc && !rempty) begin
                if (q_rd.size() == 0) begin
                    chk("rd_unexpected", 32'd1, 32'd0);
                end else begin
                    logic [7:0] ed;
                    ed = q_rd.pop_front();
                    chk("rd_data", {24'd0, tb_mem[mem_raddr]}, {24'd0, ed});
                end
            end
        end
    end

    task automatic push_wr(input logic [7:0] d);
        wr_t e;
        e.d = d;
        e.a = wcount[3:0];
        q_wr.push_back(e);
        wcount++;
    endtask

    task automatic push_rd(input logic [7:0] d);
        q_rd.push_back(d);
    endtask

    // Compare count and flag vector against what count c implies.
    task automatic check_flags(input string nm, input int c);
        logic [4:0] ec;
        logic [4:0] ef;
        ec = c[4:0];
        ef = {(c == 0), (c == 16), (c >= 14), (c <= 2), exp_uf};
        chk({nm, "_count"}, {27'd0, count}, {27'd0, ec});
        chk({nm, "_flags"}, {27'd0, rempty, wfull, almost_full, almost_empty, underflow},
            {27'd0, ef});
    endtask

    // One clock of stimulus; grants are checked at the falling edge.
    task automatic cyc(input string nm, input logic r0, input logic [7:0] d0,
                       input logic r1, input logic [7:0] d1, input logic ri,
                       input logic eg0, input logic eg1);
        req0 = r0; wdata0 = d0; req1 = r1; wdata1 = d1; rinc = ri;
        @(negedge wclk);
        chk({nm, "_gnt"}, {30'd0, gnt1, gnt0}, {30'd0, eg1, eg0});
        @(posedge wclk);
        #1;
        req0 = 1'b0; req1 = 1'b0; rinc = 1'b0;
    endtask

    task automatic do_reset();
        req0 = 1'b0; req1 = 1'b0; rinc = 1'b0;
        wrst = 1'b1;
        exp_uf = 1'b0;
        wcount = 0;
        @(posedge wclk);
        #1;
        check_flags("reset", 0);
        chk("reset_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        wrst = 1'b0;
    endtask

    initial begin
        wrst = 1'b1; req0 = 1'b0; req1 = 1'b0; rinc = 1'b0;
        wdata0 = 8'h00; wdata1 = 8'h00;
        do_reset();

        // Single write of A5, visible next edge, then popped.
        push_wr(8'hA5);
        cyc("w_a5", 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check_flags("after_a5", 1);
        push_rd(8'hA5);
        cyc("r_a5", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check_flags("after_pop_a5", 0);

        // Round-robin: both request for 4 cycles -> 0,1,0,1.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            logic [7:0] d0, d1;
            d0 = 8'h10 + 8'(i);
            d1 = 8'h20 + 8'(i);
            push_wr((i % 2 == 0) ? d0 : d1);
            cyc("rr", 1'b1, d0, 1'b1, d1, 1'b0, (i % 2 == 0), (i % 2 == 1));
        end
        check_flags("rr_done", 4);

        // Asynchronous reset mid-cycle discards contents immediately.
        #2 wrst = 1'b1;
        #1 check_flags("async_rst", 0);
        @(posedge wclk);
        #1 wrst = 1'b0;
        wcount = 0;

        // Fill to full with requester 1 only.
        for (int i = 0; i < 16; i++) begin
            push_wr(8'h40 + 8'(i));
            cyc("fill", 1'b0, 8'h00, 1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b1);
            check_flags("fill", i + 1);
        end
        // 17th request is refused.
        cyc("w17", 1'b1, 8'hEE, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check_flags("w17", 16);

        // Full with pop and write together: no grant this cycle.
        push_rd(8'h40);
        cyc("full_pop", 1'b1, 8'hE0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check_flags("full_pop", 15);
        push_wr(8'hE0);
        cyc("refill", 1'b1, 8'hE0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check_flags("refill", 16);

        // Drain everything in order.
        for (int i = 0; i < 16; i++) begin
            push_rd((i < 15) ? (8'h41 + 8'(i)) : 8'hE0);
            cyc("drain", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            check_flags("drain", 15 - i);
        end

        // Pop on empty with a simultaneous write: write lands, underflow sets.
        push_wr(8'h77);
        cyc("uf_wr", 1'b1, 8'h77, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        exp_uf = 1'b1;
        check_flags("uf_wr", 1);
        push_rd(8'h77);
        cyc("uf_pop", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check_flags("uf_sticky", 0);
        cyc("uf_again", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check_flags("uf_again", 0);
        do_reset();
        check_flags("uf_cleared", 0);

        // 40 words across pointer wrap with concurrent write+pop.
        for (int i = 0; i < 50; i++) begin
            logic [7:0] d;
            logic       wr, rd, use1;
            d    = 8'(i * 7 + 3);
            wr   = (i < 40);
            rd   = (i >= 10);
            use1 = (i % 2 == 1);
            if (wr) push_wr(d);
            if (rd) push_rd(8'((i - 10) * 7 + 3));
            cyc("wrap", wr & ~use1, d, wr & use1, d, rd, wr & ~use1, wr & use1);
            check_flags("wrap", (i < 10) ? (i + 1) : ((i < 40) ? 10 : (49 - i)));
        end

        chk("wr_queue_empty", q_wr.size(), 32'd0);
        chk("rd_queue_empty", q_rd.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arb_ctrl.md
FIFO_WR_ARB_CTRL -- requirements
Module: fifo_wr_arb_ctrl

Interface
REQ-001 Parameter DATASIZE, default 8, width of the memory data word.
REQ-002 Parameter ADDRSIZE, default 4, number of memory address bits; depth = 2**ADDRSIZE.
REQ-003 Parameter AFULL_TH, default 2**ADDRSIZE-2, count at or above which almost_full asserts.
REQ-004 Parameter AEMPTY_TH, default 2, count at or below which almost_empty asserts.
REQ-005 wclk  in  1  single clock for the whole block; all state updates on its rising edge.
REQ-006 wrst  in  1  asynchronous, active-high reset.
REQ-007 req0, req1  in  1 each  write requests from requester 0 and requester 1.
REQ-008 wdata0, wdata1  in  DATASIZE each  write data of requester 0 and requester 1.
REQ-009 gnt0, gnt1  out  1 each  write grant; a word is written on the edge where grant is high.
REQ-010 rinc  in  1  read-pop request from the consumer.
REQ-011 rempty  out  1  FIFO empty.
REQ-012 wfull  out  1  FIFO full; also drives the memory write-block input.
REQ-013 count  out  ADDRSIZE+1  number of stored words, 0..2**ADDRSIZE.
REQ-014 almost_full, almost_empty  out  1 each  threshold flags.
REQ-015 underflow  out  1  sticky error: pop attempted while empty.
REQ-016 mem_wdata  out  DATASIZE, mem_waddr  out  ADDRSIZE, mem_wclken  out  1, mem_raddr  out  ADDRSIZE  connect to the memory write/read ports.

Function
REQ-017 The block shall hold write pointer wptr and read pointer rptr, each ADDRSIZE+1 bits binary, wrapping modulo 2**(ADDRSIZE+1).
REQ-018 rempty shall be (wptr == rptr); wfull shall be (MSBs differ and lower ADDRSIZE bits equal); both are combinational from the registered pointers.
REQ-019 count shall equal (wptr - rptr) modulo 2**(ADDRSIZE+1).
REQ-020 almost_full shall be (count >= AFULL_TH); almost_empty shall be (count <= AEMPTY_TH).
REQ-021 Grants shall be combinational in the request cycle, at most one high, and both low while wfull.
REQ-022 One requester active and not full: that requester shall be granted.
REQ-023 Both active and not full: the requester not granted most recently shall be granted (round-robin).
REQ-024 After reset the last-granted marker shall point to requester 1, so requester 0 wins the first tie.
REQ-025 mem_wclken shall equal (gnt0 | gnt1); mem_wdata shall mux the granted requester's data; mem_waddr = wptr[ADDRSIZE-1:0].
REQ-026 On an edge with a grant high, wptr shall increment by 1 and the last-granted marker shall update.
REQ-027 mem_raddr shall be rptr[ADDRSIZE-1:0]; the head word is valid at the memory read port whenever rempty is low (first-word fall-through).
REQ-028 rinc with rempty low shall increment rptr by 1 on that edge.
REQ-029 rinc with rempty high shall leave rptr unchanged and set underflow on that edge; underflow holds until reset.
REQ-030 Simultaneous write grant and valid pop shall update both pointers, leaving count unchanged.
REQ-031 When full, a pop in the same cycle shall not enable a write; the write is granted the next cycle at the earliest.
REQ-032 When empty, a write in the same cycle as rinc shall complete; the pop is treated as underflow.
REQ-033 A written word shall clear rempty at the following edge (one-cycle write-to-visible latency).

Reset
REQ-034 While wrst is high: wptr = rptr = 0, last-granted = requester 1, underflow = 0; hence rempty = 1, wfull = 0, count = 0, almost_empty = 1, almost_full = 0, gnt0 = gnt1 = 0 only if no req (grants stay combinational).
REQ-035 Reset asserted mid-operation shall discard all stored words immediately, without waiting for a clock edge.

Verification
REQ-036 Reset, then req0 = 1 with wdata0 = 8'hA5 for one cycle -> gnt0 = 1, next cycle rempty = 0, count = 1, memory head = A5.
REQ-037 req0 = req1 = 1 held for 4 cycles from reset -> grants in order 0,1,0,1; count = 4.
REQ-038 16 writes with default parameters -> wfull = 1, count = 16, almost_full from count 14; a 17th request gets no grant.
REQ-039 Full FIFO, req0 and rinc in the same cycle -> no grant that cycle, count = 15; next cycle grant, count = 16.
REQ-040 Empty FIFO, rinc = 1 -> underflow = 1 and sticky; rptr and count unchanged; wrst clears it.
REQ-041 Fill and drain 40 words across pointer wrap -> read data order equals write order; flags correct at every boundary.
